// File: rtl/morse_msg_sequencer.sv
`timescale 1ns/1ps
// Morse message sequencer: plays a latched S/O pattern through the buzzer block.
// It inserts timed character and word gaps, counts repeat passes and runs a per-character watchdog.
module morse_msg_sequencer #(
  parameter logic [15:0] T1MS        = 16'd49_999,
  parameter logic [9:0]  GAP_MS      = 10'd300,
  parameter logic [9:0]  WORD_GAP_MS = 10'd700,
  parameter logic [11:0] TIMEOUT_MS  = 12'd2000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Req_Sig,
  input  logic       Abort_Sig,
  input  logic [7:0] Pattern,
  input  logic [2:0] Pattern_Len,
  input  logic [3:0] Repeat,
  input  logic       Buz_Done,
  output logic [1:0] Buz_Start,
  output logic       Busy,
  output logic       Done_Sig,
  output logic       Err_Sig,
  output logic [2:0] Char_Index
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_WGAP,
    S_FINISH
  } state_t;

  localparam logic [1:0] CMD_S    = 2'b10;
  localparam logic [1:0] CMD_O    = 2'b01;
  localparam logic [1:0] CMD_NONE = 2'b00;

  state_t      state_q;
  logic [15:0] cyc_q;
  logic [15:0] cyc_d;
  logic [11:0] ms_q;
  logic [11:0] ms_d;
  logic [11:0] ms_inc;
  logic        tick;
  logic        gap_hit;
  logic        wgap_hit;
  logic        tmo_hit;

  logic [7:0]  pat_q;
  logic [2:0]  len_q;
  logic [3:0]  rep_q;
  logic [3:0]  pass_q;
  logic [2:0]  idx_q;
  logic [2:0]  idx_inc;

  logic [1:0]  buz_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  function automatic logic [1:0] cmd_of(input logic is_s);
    return is_s ? CMD_S : CMD_O;
  endfunction

  // A wait of N ms ends on the tick that would make the ms count reach N.
  always_comb begin
    tick     = (cyc_q == T1MS);
    ms_inc   = ms_q + 12'd1;
    cyc_d    = tick ? 16'd0 : cyc_q + 16'd1;
    ms_d     = tick ? ms_inc : ms_q;
    gap_hit  = tick && (ms_inc == {2'b00, GAP_MS});
    wgap_hit = tick && (ms_inc == {2'b00, WORD_GAP_MS});
    tmo_hit  = tick && (ms_inc == TIMEOUT_MS);
    idx_inc  = idx_q + 3'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      ms_q    <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= '0;
      pass_q  <= '0;
      idx_q   <= '0;
      buz_q   <= CMD_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cyc_q  <= cyc_d;
      ms_q   <= ms_d;
      if ((state_q != S_IDLE) && Abort_Sig) begin
        state_q <= S_IDLE;
        buz_q   <= CMD_NONE;
        busy_q  <= 1'b0;
        cyc_q   <= '0;
        ms_q    <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            cyc_q <= '0;
            ms_q  <= '0;
            if (Req_Sig) begin
              pat_q   <= Pattern;
              len_q   <= Pattern_Len;
              rep_q   <= Repeat;
              pass_q  <= '0;
              idx_q   <= '0;
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              buz_q   <= cmd_of(Pattern[0]);
              state_q <= S_ISSUE;
            end
          end

          // Buzzer completion outranks a watchdog expiry in the same cycle.
          S_ISSUE: begin
            if (Buz_Done) begin
              buz_q   <= CMD_NONE;
              cyc_q   <= '0;
              ms_q    <= '0;
              state_q <= S_GAP;
            end else if (tmo_hit) begin
              buz_q   <= CMD_NONE;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              cyc_q   <= '0;
              ms_q    <= '0;
              state_q <= S_IDLE;
            end
          end

          S_GAP: begin
            if (gap_hit) begin
              cyc_q <= '0;
              ms_q  <= '0;
              if (idx_q < len_q) begin
                idx_q   <= idx_inc;
                buz_q   <= cmd_of(pat_q[idx_inc]);
                state_q <= S_ISSUE;
              end else if (pass_q < rep_q) begin
                pass_q  <= pass_q + 4'd1;
                state_q <= S_WGAP;
              end else begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_FINISH;
              end
            end
          end

          S_WGAP: begin
            if (wgap_hit) begin
              cyc_q   <= '0;
              ms_q    <= '0;
              idx_q   <= '0;
              buz_q   <= cmd_of(pat_q[0]);
              state_q <= S_ISSUE;
            end
          end

          S_FINISH: begin
            cyc_q   <= '0;
            ms_q    <= '0;
            state_q <= S_IDLE;
          end

          default: begin
            buz_q   <= CMD_NONE;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign Buz_Start  = buz_q;
  assign Busy       = busy_q;
  assign Done_Sig   = done_q;
  assign Err_Sig    = err_q;
  assign Char_Index = idx_q;

endmodule

// File: tb/tb_morse_msg_sequencer.sv
`timescale 1ns/1ps
// Bench for morse_msg_sequencer: a segment-level timeline model predicts every output
// on every cycle; directed runs pin timing and command order with literal values.
module tb_morse_msg_sequencer;

  localparam int T1       = 9;
  localparam int GAP_CYC  = 3 * (T1 + 1);
  localparam int WGAP_CYC = 7 * (T1 + 1);
  localparam int TMO_CYC  = 20 * (T1 + 1);

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Req_Sig = 1'b0;
  logic       Abort_Sig = 1'b0;
  logic [7:0] Pattern = '0;
  logic [2:0] Pattern_Len = '0;
  logic [3:0] Repeat = '0;
  logic       Buz_Done = 1'b0;
  logic [1:0] Buz_Start;
  logic       Busy;
  logic       Done_Sig;
  logic       Err_Sig;
  logic [2:0] Char_Index;

  morse_msg_sequencer #(
    .T1MS        (16'd9),
    .GAP_MS      (10'd3),
    .WORD_GAP_MS (10'd7),
    .TIMEOUT_MS  (12'd20)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Req_Sig     (Req_Sig),
    .Abort_Sig   (Abort_Sig),
    .Pattern     (Pattern),
    .Pattern_Len (Pattern_Len),
    .Repeat      (Repeat),
    .Buz_Done    (Buz_Done),
    .Buz_Start   (Buz_Start),
    .Busy        (Busy),
    .Done_Sig    (Done_Sig),
    .Err_Sig     (Err_Sig),
    .Char_Index  (Char_Index)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] buz;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] idx;
  } exp_t;

  exp_t       tl[$];
  exp_t       tail = '0;
  exp_t       cmp_e;
  exp_t       cmp_g;
  int         cyc = 0;
  int         base = 0;
  int         errors = 0;
  int         checks = 0;
  bit         chk_en = 1'b0;
  int         lat = 50;
  bit         spur = 1'b0;
  int         age = 0;
  logic [1:0] cmd_log[$];
  logic [1:0] want[$];
  int         done_cnt = 0;
  int         done_t = -1;
  int         err_t = -1;
  logic [1:0] prev_buz = 2'b00;
  logic       prev_err = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic exp_t exp_at(input int k);
    if (k >= 0 && k < tl.size()) return tl[k];
    return tail;
  endfunction

  // Timeline index k = outputs just after the k-th edge following the accept edge.
  task automatic build(input logic [7:0] pat, input logic [2:0] len, input logic [3:0] rep,
                       input int d, input int ta);
    exp_t e;
    exp_t prev;
    tl.delete();
    if (d == 0) begin
      e.buz = pat[0] ? 2'b10 : 2'b01;
      e.busy = 1'b1; e.done = 1'b0; e.err = 1'b0; e.idx = 3'd0;
      repeat (TMO_CYC) tl.push_back(e);
      tail = '0;
      tail.err = 1'b1;
    end else begin
      for (int p = 0; p <= int'(rep); p++) begin
        for (int ch = 0; ch <= int'(len); ch++) begin
          e.buz = pat[ch] ? 2'b10 : 2'b01;
          e.busy = 1'b1; e.done = 1'b0; e.err = 1'b0; e.idx = 3'(ch);
          repeat (d) tl.push_back(e);
          e.buz = 2'b00;
          repeat (GAP_CYC) tl.push_back(e);
          if (ch == int'(len) && p < int'(rep)) repeat (WGAP_CYC) tl.push_back(e);
        end
      end
      e.buz = 2'b00; e.busy = 1'b0; e.done = 1'b1; e.err = 1'b0; e.idx = len;
      tl.push_back(e);
      tail = '0;
      tail.idx = len;
    end
    if (ta > 0 && ta < tl.size()) begin
      prev = tl[ta-1];
      while (tl.size() > ta) void'(tl.pop_back());
      tail = '0;
      tail.err = prev.err;
      tail.idx = prev.idx;
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic chk_cmds(input string name);
    chk({name, "_count"}, cmd_log.size(), want.size());
    for (int i = 0; i < want.size(); i++)
      chk($sformatf("%s_cmd%0d", name, i), (i < cmd_log.size()) ? int'(cmd_log[i]) : -1, int'(want[i]));
  endtask

  // ta: -1 no abort, -2 random abort point, >0 abort sampled at that timeline index.
  task automatic run(input logic [7:0] pat, input logic [2:0] len, input logic [3:0] rep,
                     input int d, input int ta, input bit noise);
    exp_t e;
    int   n;
    int   ta_l;
    ta_l = ta;
    lat = d;
    spur = noise;
    Pattern = pat; Pattern_Len = len; Repeat = rep;
    Req_Sig = 1'b1;
    @(posedge CLK); #1;
    Req_Sig = 1'b0;
    build(pat, len, rep, d, ta_l);
    if (ta_l == -2) begin
      ta_l = int'($urandom_range(1, tl.size() - 1));
      build(pat, len, rep, d, ta_l);
    end
    base = cyc;
    cmd_log.delete(); done_cnt = 0; done_t = -1; err_t = -1;
    n = tl.size() + 2;
    for (int t = 0; t < n; t++) begin
      Abort_Sig = (ta_l > 0 && t + 1 == ta_l);
      if (noise) begin
        e = exp_at(t);
        Req_Sig = e.busy && ($urandom_range(0, 3) == 0);
        Pattern = 8'($urandom);
        Pattern_Len = 3'($urandom);
        Repeat = 4'($urandom);
      end
      @(posedge CLK); #1;
    end
    Abort_Sig = 1'b0;
    Req_Sig = 1'b0;
  endtask

  // Buzzer stand-in: done pulse `lat` cycles after a command appears (lat 0 = never).
  initial begin
    forever begin
      @(posedge CLK); #1;
      if (Buz_Start != 2'b00) begin
        age = age + 1;
        Buz_Done = (lat != 0) && (age == lat);
      end else begin
        age = 0;
        Buz_Done = spur && ($urandom_range(0, 7) == 0);
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      cmp_e = exp_at(cyc - base);
      cmp_g = {Buz_Start, Busy, Done_Sig, Err_Sig, Char_Index};
      checks++;
      if (cmp_g !== cmp_e) begin
        errors++;
        $display("FAIL cycle_%0d: got buz=%b busy=%b done=%b err=%b idx=%0d, expected buz=%b busy=%b done=%b err=%b idx=%0d",
                 cyc - base, cmp_g.buz, cmp_g.busy, cmp_g.done, cmp_g.err, cmp_g.idx,
                 cmp_e.buz, cmp_e.busy, cmp_e.done, cmp_e.err, cmp_e.idx);
      end
    end
  end

  always @(negedge CLK) begin
    if (Buz_Start != 2'b00 && prev_buz == 2'b00) cmd_log.push_back(Buz_Start);
    if (Done_Sig) begin
      done_cnt = done_cnt + 1;
      done_t = cyc - base;
    end
    if (Err_Sig && !prev_err) err_t = cyc - base;
    prev_buz = Buz_Start;
    prev_err = Err_Sig;
  end

  initial begin
    logic [7:0] rp;
    logic [2:0] rl;
    logic [3:0] rr;
    int         rd;
    int         rta;

    RST = 1'b1;
    repeat (3) @(posedge CLK); #1;
    chk_en = 1'b1;
    chk("reset_outputs", int'({Buz_Start, Busy, Done_Sig, Err_Sig, Char_Index}), 0);
    RST = 1'b0;
    repeat (2) @(posedge CLK); #1;

    run(8'b0000_0101, 3'd2, 4'd0, 50, -1, 1'b0);
    want = '{2'b10, 2'b01, 2'b10};
    chk_cmds("sos");
    chk("sos_done_count", done_cnt, 1);
    chk("sos_done_time", done_t, 240);

    run(8'b0000_0001, 3'd0, 4'd1, 50, -1, 1'b0);
    want = '{2'b10, 2'b10};
    chk_cmds("rep1");
    chk("rep1_done_time", done_t, 230);

    run(8'b0000_0001, 3'd0, 4'd0, 0, -1, 1'b0);
    chk("tmo_err_time", err_t, 200);
    chk("tmo_done_count", done_cnt, 0);
    chk("tmo_err_held", int'(Err_Sig), 1);

    run(8'b0000_0101, 3'd2, 4'd0, 50, 130, 1'b1);
    chk("abort_done_count", done_cnt, 0);
    chk("abort_cmd_count", cmd_log.size(), 2);
    chk("abort_err_cleared", int'(Err_Sig), 0);

    run(8'hA5, 3'd7, 4'd0, 50, -1, 1'b0);
    want = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10};
    chk_cmds("a5");
    chk("a5_done_time", done_t, 640);

    run(8'b0000_0000, 3'd0, 4'd15, 5, -1, 1'b0);
    chk("rep15_cmd_count", cmd_log.size(), 16);
    chk("rep15_done_time", done_t, 1610);

    lat = 50; spur = 1'b0;
    Pattern = 8'b0000_0110; Pattern_Len = 3'd2; Repeat = 4'd0;
    Req_Sig = 1'b1;
    @(posedge CLK); #1;
    Req_Sig = 1'b0;
    build(8'b0000_0110, 3'd2, 4'd0, 50, -1);
    base = cyc;
    repeat (100) @(posedge CLK);
    #1;
    chk("pre_reset_buz", int'(Buz_Start), 2);
    #2;
    RST = 1'b1;
    tl.delete();
    tail = '0;
    #1;
    chk("reset_async", int'({Buz_Start, Busy, Done_Sig, Err_Sig, Char_Index}), 0);
    repeat (2) @(posedge CLK); #1;
    RST = 1'b0;
    repeat (2) @(posedge CLK); #1;
    run(8'b0000_0110, 3'd2, 4'd0, 30, -1, 1'b1);
    want = '{2'b01, 2'b10, 2'b10};
    chk_cmds("post_reset");
    chk("post_reset_done_time", done_t, 180);

    for (int i = 0; i < 15; i++) begin
      rp = 8'($urandom);
      rl = 3'($urandom_range(0, 7));
      rr = 4'($urandom_range(0, 2));
      rd = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40));
      rta = ($urandom_range(0, 3) == 0) ? -2 : -1;
      run(rp, rl, rr, rd, rta, 1'b1);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morse_msg_sequencer.md
Name: morse_msg_sequencer

Overview:
- Sequences the Morse buzzer function block. Plays a latched pattern of up to 8 characters, each S (dot group) or O (dash group), repeated a programmable number of times.
- Drives the buzzer's 2-bit character command, waits for its done pulse, and inserts timed inter-character and inter-word silences.
- Sits between user/key logic and the buzzer function block.
- Provides busy/done/error status and a per-character watchdog.

Parameters:
- T1MS, 16'd49_999, clocks per 1 ms tick minus 1 (50 MHz).
- GAP_MS, 10'd300, silence between characters, in ms.
- WORD_GAP_MS, 10'd700, silence between pattern repeats, in ms.
- TIMEOUT_MS, 12'd2000, max wait for buzzer done per character, in ms.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- Req_Sig  in  1  start request; sampled only in IDLE.
- Abort_Sig  in  1  stop playback immediately.
- Pattern  in  8  character bits; bit i: 1 = S, 0 = O; bit 0 plays first.
- Pattern_Len  in  3  number of characters minus 1 (0 = 1 char, 7 = 8 chars).
- Repeat  in  4  extra passes (0 = play once, 15 = 16 passes).
- Buz_Done  in  1  one-cycle done pulse from the buzzer block.
- Buz_Start  out  2  command to buzzer: 10 = S, 01 = O, 00 = idle.
- Busy  out  1  high from request accept to finish/abort/error.
- Done_Sig  out  1  one-cycle pulse on normal completion.
- Err_Sig  out  1  sticky watchdog error; cleared by the next accepted Req_Sig or by reset.
- Char_Index  out  3  index of the character currently playing or last played.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-character): all outputs 0, state IDLE, all counters 0.
- Pattern, Pattern_Len and Repeat are latched on accept. Later input changes have no effect until the next accept.
- ms timer:
  - Cycle counter 0..T1MS, producing a tick at T1MS; ms counter increments on each tick.
  - Both counters clear on every state entry.
  - A state that waits N ms exits exactly N*(T1MS+1) cycles after entry.
- States and transitions:
  - IDLE: Req_Sig=1 at edge n → latch inputs, Err_Sig=0, Busy=1, Char_Index=0, goto ISSUE. Buz_Start is valid at n+1.
  - ISSUE: Buz_Start = 10 if latched bit[Char_Index]=1, else 01; held steady.
    - Buz_Done=1 → Buz_Start=00 next cycle, goto GAP.
    - ms count reaches TIMEOUT_MS → Buz_Start=00, Err_Sig=1, goto IDLE with Busy=0; no Done_Sig.
  - GAP: wait GAP_MS.
    - If Char_Index < latched Pattern_Len: Char_Index+1, goto ISSUE.
    - Else, if pass counter < latched Repeat: pass counter+1, goto WGAP.
    - Else goto FINISH.
    - A single-character pattern still takes one GAP before FINISH.
  - WGAP: wait WORD_GAP_MS, Char_Index=0, goto ISSUE.
  - FINISH: Done_Sig=1 for exactly one cycle, Busy=0, goto IDLE.
- Buz_Start returns to 00 for at least the full GAP before each new character, so the buzzer always sees a fresh command after its done pulse.
- Pass counter: 4-bit, cleared on accept, never wraps (compared against Repeat ≤ 15).
- Abort_Sig=1 in any non-IDLE state: next cycle Buz_Start=00, Busy=0, goto IDLE; no Done_Sig, Err_Sig unchanged.
- Abort has priority over Buz_Done and timeout in the same cycle.
- Req_Sig while Busy is ignored, not queued. Req_Sig held high is accepted again one cycle after return to IDLE.
- Buz_Done outside ISSUE is ignored.
- Buz_Done and timeout in the same cycle: Buz_Done wins.
- Done_Sig and Err_Sig are never asserted for the same request.

Test Plan (T1MS=9, GAP_MS=3, WORD_GAP_MS=7, TIMEOUT_MS=20; buzzer model returns Buz_Done 50 cycles after a nonzero command):
- Reset mid-ISSUE with Buz_Start=10 → all outputs 0 immediately; Req_Sig after release starts at Char_Index 0.
- SOS: Pattern=8'b00000101, Len=2, Repeat=0, Req pulse → Buz_Start sequence 10,01,10. Each command drops to 00 the cycle after Buz_Done. 30-cycle gaps between characters. Single Done_Sig after last GAP; Busy falls the same cycle.
- Repeat=1, Pattern=8'b1, Len=0 → S, GAP 30, WGAP 70, S, GAP 30, Done_Sig. Exactly 2 commands issued.
- Model never responds → Err_Sig=1 and Buz_Start=00 exactly 200 cycles after ISSUE entry, Busy=0, no Done_Sig. Next Req_Sig clears Err_Sig.
- Abort_Sig asserted in the same cycle as Buz_Done during second character → Buz_Start=00, Busy=0 next cycle, no Done_Sig. A Req_Sig during playback is ignored.
- Len=7, Pattern=8'hA5 → 8 commands in order 10,01,10,01,01,10,01,10; Char_Index steps 0..7.
